// File: rtl/topo_game_ctrl.sv
// Whack-a-mole sequencer: spawns moles at LFSR-chosen cells, steers a cursor and scores strikes.
// Define SPEEDUP_EN to shorten the mole lifetime after every scored hit within a game.
module topo_game_ctrl #(
    parameter int         N_CELLS        = 9,
    parameter int         GRID_W         = 3,
    parameter int         TOPO_TICKS     = 20,
    parameter int         COOLDOWN_TICKS = 4,
    parameter int         GAME_MOLES     = 16,
    parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_hit,
    input  logic [N_CELLS-1:0] hit,
    output logic [N_CELLS-1:0] poner_topo,
    output logic [N_CELLS-1:0] select,
    output logic               golpe,
    output logic [7:0]         score,
    output logic [7:0]         misses,
    output logic               busy,
    output logic               game_over
);

    localparam int N_ROWS = N_CELLS / GRID_W;
    localparam int T_MAX  = (TOPO_TICKS > COOLDOWN_TICKS) ? TOPO_TICKS : COOLDOWN_TICKS;
    localparam int TW     = $clog2(T_MAX + 1);

    localparam logic [3:0]         LAST_ROW  = 4'(N_ROWS - 1);
    localparam logic [3:0]         LAST_COL  = 4'(GRID_W - 1);
    localparam logic [4:0]         N_CELLS_W = 5'(N_CELLS);
    localparam logic [7:0]         MOLES_W   = 8'(GAME_MOLES);
    localparam logic [TW-1:0]      COOL_LOAD = TW'(COOLDOWN_TICKS - 1);
    localparam logic [N_CELLS-1:0] CELL0     = N_CELLS'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPAWN,
        S_UP,
        S_COOL,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         lfsr_q, lfsr_d;
    logic [3:0]         row_q, row_d;
    logic [3:0]         col_q, col_d;
    logic [3:0]         cursor_d;
    logic [N_CELLS-1:0] select_q, select_d;
    logic [N_CELLS-1:0] poner_q, poner_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [TW-1:0]      life_load;
    logic [7:0]         score_q, score_d;
    logic [7:0]         misses_q, misses_d;
    logic [7:0]         count_q, count_d;
    logic [3:0]         cand;
    logic               cand_ok;

`ifdef SPEEDUP_EN
    localparam logic [TW-1:0] LIFE_INIT  = TW'(TOPO_TICKS);
    localparam logic [TW-1:0] LIFE_STEP  = TW'(TOPO_TICKS / 8);
    localparam logic [TW-1:0] LIFE_FLOOR = TW'(TOPO_TICKS / 4);

    logic [TW-1:0] life_q, life_d;

    assign life_load = life_q - TW'(1);
`else
    assign life_load = TW'(TOPO_TICKS - 1);
`endif

    // Fibonacci LFSR, taps 8,6,5,4; the low nibble proposes the next mole cell.
    assign lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign cand    = lfsr_q[3:0];
    assign cand_ok = ({1'b0, cand} < N_CELLS_W);

    // Cursor: one move per cycle, up > down > left > right, wrapping inside row/column.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (btn_up) begin
            row_d = (row_q == 4'd0) ? LAST_ROW : row_q - 4'd1;
        end else if (btn_down) begin
            row_d = (row_q == LAST_ROW) ? 4'd0 : row_q + 4'd1;
        end else if (btn_left) begin
            col_d = (col_q == 4'd0) ? LAST_COL : col_q - 4'd1;
        end else if (btn_right) begin
            col_d = (col_q == LAST_COL) ? 4'd0 : col_q + 4'd1;
        end
        cursor_d = 4'(row_d * GRID_W) + col_d;
        select_d = CELL0 << cursor_d;
    end

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        poner_d  = poner_q;
        timer_d  = timer_q;
        score_d  = score_q;
        misses_d = misses_q;
        count_d  = count_q;
`ifdef SPEEDUP_EN
        life_d   = life_q;
`endif
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    score_d  = 8'd0;
                    misses_d = 8'd0;
                    count_d  = 8'd0;
                    poner_d  = '0;
`ifdef SPEEDUP_EN
                    life_d   = LIFE_INIT;
`endif
                    state_d  = S_SPAWN;
                end
            end
            S_SPAWN: begin
                if (cand_ok) begin
                    poner_d = CELL0 << cand;
                    timer_d = life_load;
                    count_d = count_q + 8'd1;
                    state_d = S_UP;
                end
            end
            S_UP: begin
                timer_d = timer_q - TW'(1);
                // A strike landing on the final cycle still counts as a hit.
                if (|hit) begin
                    score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                    poner_d = '0;
                    timer_d = COOL_LOAD;
                    state_d = S_COOL;
`ifdef SPEEDUP_EN
                    life_d  = (life_q < LIFE_FLOOR + LIFE_STEP) ? LIFE_FLOOR : life_q - LIFE_STEP;
`endif
                end else if (timer_q == '0) begin
                    misses_d = (misses_q == 8'hFF) ? misses_q : misses_q + 8'd1;
                    poner_d  = '0;
                    timer_d  = COOL_LOAD;
                    state_d  = S_COOL;
                end
            end
            S_COOL: begin
                timer_d = timer_q - TW'(1);
                if (timer_q == '0) begin
                    state_d = (count_q == MOLES_W) ? S_DONE : S_SPAWN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            lfsr_q   <= LFSR_SEED;
            row_q    <= 4'd0;
            col_q    <= 4'd0;
            select_q <= CELL0;
            poner_q  <= '0;
            timer_q  <= '0;
            score_q  <= 8'd0;
            misses_q <= 8'd0;
            count_q  <= 8'd0;
`ifdef SPEEDUP_EN
            life_q   <= LIFE_INIT;
`endif
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            row_q    <= row_d;
            col_q    <= col_d;
            select_q <= select_d;
            poner_q  <= poner_d;
            timer_q  <= timer_d;
            score_q  <= score_d;
            misses_q <= misses_d;
            count_q  <= count_d;
`ifdef SPEEDUP_EN
            life_q   <= life_d;
`endif
        end
    end

    // The strike is combinational so the cells judge it against the current select.
    assign golpe      = btn_hit && (state_q == S_UP);
    assign poner_topo = poner_q;
    assign select     = select_q;
    assign score      = score_q;
    assign misses     = misses_q;
    assign busy       = (state_q == S_SPAWN) || (state_q == S_UP) || (state_q == S_COOL);
    assign game_over  = (state_q == S_DONE);

endmodule

// File: tb/tb_topo_game_ctrl.sv
// Scoreboard bench for topo_game_ctrl: predicted moles are queued, a monitor checks each one shown.
module tb_topo_game_ctrl;

    localparam int N  = 9;
    localparam int GW = 3;
    localparam int NR = N / GW;
    localparam int TT = 20;
    localparam int CD = 4;
    localparam int GM = 4;
`ifdef SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
`else
    localparam bit SPEEDUP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_hit = 1'b0;
    logic [N-1:0] hit, poner_topo, select;
    logic         golpe, busy, game_over;
    logic [7:0]   score, misses;

    always #5 clk = ~clk;

    // Cell model: a cell reports HIT when struck while it both shows a mole and is selected.
    assign hit = golpe ? (poner_topo & select) : '0;

    topo_game_ctrl #(
        .N_CELLS(N), .GRID_W(GW), .TOPO_TICKS(TT), .COOLDOWN_TICKS(CD),
        .GAME_MOLES(GM), .LFSR_SEED(8'hA5)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_hit(btn_hit), .hit(hit), .poner_topo(poner_topo), .select(select),
        .golpe(golpe), .score(score), .misses(misses), .busy(busy), .game_over(game_over)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [31:0] onehot(input int i);
        logic [31:0] one = 32'd1;
        return one << i;
    endfunction

    function automatic int life_after(input int hits);
        int l = TT - hits * (TT / 8);
        if (!SPEEDUP) return TT;
        return (l < TT / 4) ? TT / 4 : l;
    endfunction

    // Reference LFSR and cycle index, both restarting on reset.
    logic [7:0] m_lfsr;
    int         cyc;
    always @(posedge clk) begin
        if (reset) begin
            m_lfsr <= 8'hA5;
            cyc    <= 0;
        end else begin
            m_lfsr <= lfsr_step(m_lfsr);
            cyc    <= cyc + 1;
        end
    end

    typedef struct {
        int idx;
        int appear;
        int dur;
    } mole_t;

    mole_t exp_q[$];
    int    exp_idx[GM];
    int    exp_app[GM];
    int    cur_row = 0;
    int    cur_col = 0;

    // Called on the falling edge right after the start edge: the first SPAWN cycle sees m_lfsr.
    task automatic predict(input int n, input int d0, input int d1, input int d2, input int d3);
        int         durs[GM];
        logic [7:0] v;
        int         e;
        mole_t      m;
        durs = '{d0, d1, d2, d3};
        v = m_lfsr;
        e = cyc;
        for (int k = 0; k < n; k++) begin
            for (int g = 0; g < 64 && int'(v[3:0]) >= N; g++) begin
                v = lfsr_step(v);
                e++;
            end
            m.idx = int'(v[3:0]);
            m.appear = e + 1;
            m.dur = durs[k];
            exp_q.push_back(m);
            exp_idx[k] = m.idx;
            exp_app[k] = m.appear;
            for (int s = 0; s < durs[k] + CD + 1; s++) v = lfsr_step(v);
            e = e + 1 + durs[k] + CD;
        end
    endtask

    // Monitor: every mole the DUT shows is matched against the next queued prediction.
    initial begin
        logic [N-1:0] prev = '0;
        mole_t        cur;
        int           up_cnt = 0;
        cur = '{idx: 0, appear: 0, dur: 0};
        forever begin
            @(negedge clk);
            if (poner_topo != '0 && prev == '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_mole", 32'(poner_topo), 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    check("mole_cell", 32'(poner_topo), onehot(cur.idx));
                    check("mole_appear_cycle", cyc, cur.appear);
                end
                up_cnt = 1;
            end else if (poner_topo != '0) begin
                up_cnt++;
            end else if (prev != '0) begin
                check("mole_visible_cycles", up_cnt, cur.dur);
            end
            prev = poner_topo;
        end
    end

    task automatic wait_cyc(input int n);
        int t = 0;
        while (cyc < n && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("reach_cycle", cyc, n);
    endtask

    task automatic wait_game_over(input string name);
        int t = 0;
        while (game_over !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(game_over), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic press(input int dir);
        btn_up = (dir == 0);
        btn_down = (dir == 1);
        btn_left = (dir == 2);
        btn_right = (dir == 3);
        @(negedge clk);
        {btn_up, btn_down, btn_left, btn_right} = 4'b0;
    endtask

    // Steer the cursor onto the mole during its first UP cycles, then strike on hit_cyc.
    task automatic steer_and_hit(input int idx, input int app, input int hit_cyc);
        int dn = (idx / GW - cur_row + NR) % NR;
        int rt = (idx % GW - cur_col + GW) % GW;
        wait_cyc(app);
        repeat (dn) press(1);
        repeat (rt) press(3);
        cur_row = idx / GW;
        cur_col = idx % GW;
        wait_cyc(hit_cyc);
        check("cursor_on_mole", 32'(select), onehot(idx));
        btn_hit = 1'b1;
        #1;
        check("golpe_in_hit_cycle", 32'(golpe), 32'd1);
        @(negedge clk);
        btn_hit = 1'b0;
        check("golpe_one_cycle", 32'(golpe), 32'd0);
        check("mole_cleared_after_hit", 32'(poner_topo), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_select", 32'(select), 32'h001);
        check("rst_poner", 32'(poner_topo), 32'd0);
        check("rst_score", score, 32'd0);
        check("rst_misses", misses, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_game_over", 32'(game_over), 32'd0);

        // Cursor wrap and priority, starting from cell 0.
        press(2); check("left_wrap", 32'(select), onehot(2));
        press(0); check("up_wrap", 32'(select), onehot(8));
        press(3); check("right_wrap", 32'(select), onehot(6));
        press(1); check("down_wrap", 32'(select), onehot(0));
        btn_left = 1'b1;
        press(0); check("up_beats_left", 32'(select), onehot(6));
        cur_row = 2;
        cur_col = 0;

        // Game 1: no strikes, every mole times out.
        pulse_start();
        predict(GM, TT, TT, TT, TT);
        check("g1_busy", 32'(busy), 32'd1);
        wait_game_over("g1_game_over");
        check("g1_misses", misses, GM);
        check("g1_score", score, 32'd0);
        check("g1_busy_done", 32'(busy), 32'd0);
        check("g1_sb_drained", exp_q.size(), 32'd0);

        // Game 2: hit on 5th UP cycle, hit on final cycle, reset during the third mole.
        pulse_start();
        predict(3, 5, life_after(1), 4, 0);
        check("g2_restart_score", score, 32'd0);
        check("g2_restart_misses", misses, 32'd0);
        check("g2_not_over", 32'(game_over), 32'd0);
        steer_and_hit(exp_idx[0], exp_app[0], exp_app[0] + 4);
        check("g2_score_hit1", score, 32'd1);
        check("g2_busy_cool", 32'(busy), 32'd1);
        steer_and_hit(exp_idx[1], exp_app[1], exp_app[1] + life_after(1) - 1);
        check("g2_score_last_cycle_hit", score, 32'd2);
        check("g2_misses_last_cycle_hit", misses, 32'd0);
        wait_cyc(exp_app[2] + 3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cur_row = 0;
        cur_col = 0;
        check("midrst_select", 32'(select), 32'h001);
        check("midrst_poner", 32'(poner_topo), 32'd0);
        check("midrst_score", score, 32'd0);
        check("midrst_misses", misses, 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_game_over", 32'(game_over), 32'd0);
        check("midrst_sb_drained", exp_q.size(), 32'd0);
        repeat (3) @(negedge clk);

        // Game 3: fresh start after the abort; lifetime back to the full value.
        pulse_start();
        predict(GM, life_after(0), life_after(0), life_after(0), life_after(0));
        check("g3_start_score", score, 32'd0);
        check("g3_busy", 32'(busy), 32'd1);
        wait_game_over("g3_game_over");
        check("g3_misses", misses, GM);
        check("g3_score", score, 32'd0);
        check("g3_sb_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/topo_game_ctrl.md
Name: topo_game_ctrl

Overview:
- Game sequencer for a whack-a-mole grid of N_CELLS mole cells.
- Each cell takes PONER_TOPO/SELECT/GOLPE inputs and returns a combinational HIT.
- Places one mole at a time at a pseudo-random cell and moves a cursor selection from button pulses.
- Issues the strike, times out unhit moles and keeps score until a fixed number of moles have been played.

Parameters:
- N_CELLS, 9, number of cells (2..16)
- GRID_W, 3, cells per row; N_CELLS is a multiple of GRID_W
- TOPO_TICKS, 20, clk cycles a mole stays up (>=8)
- COOLDOWN_TICKS, 4, empty-grid cycles between moles (>=1)
- GAME_MOLES, 16, moles per game (1..255)
- LFSR_SEED, 8'hA5, non-zero LFSR reset value

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  pulse; starts a game from IDLE or DONE
- btn_up  in  1  one-cycle pulse, cursor up one row
- btn_down  in  1  one-cycle pulse, cursor down one row
- btn_left  in  1  one-cycle pulse, cursor left one column
- btn_right  in  1  one-cycle pulse, cursor right one column
- btn_hit  in  1  one-cycle pulse, strike at cursor
- hit  in  N_CELLS  HIT outputs of the cells
- poner_topo  out  N_CELLS  one-hot mole placement, or all zero
- select  out  N_CELLS  one-hot cursor
- golpe  out  1  strike to all cells
- score  out  8  moles hit, saturating at 255
- misses  out  8  moles timed out, saturating at 255
- busy  out  1  game in progress
- game_over  out  1  high in DONE

Behaviour:
- One clock domain (clk). Synchronous active-high reset.
- Reset values:
  - state=IDLE
  - cursor=0, so select=1 (cell 0)
  - poner_topo=0, golpe=0
  - score=0, misses=0, mole count=0
  - busy=0, game_over=0
  - lfsr=LFSR_SEED
- Reset mid-game aborts to these values on the next edge.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4.
  - Shifts every cycle when not in reset.
  - Candidate cell = lfsr[3:0].
- Cursor:
  - Register 0..N_CELLS-1; select = one-hot(cursor), registered.
  - Moves are allowed in every state.
  - Left/right wrap within the row. Up/down wrap within the column (row 0 up goes to the last row).
  - Several move pulses in one cycle: priority up > down > left > right; only one applies.
- golpe = btn_hit AND state==UP. It is combinational, the same cycle as btn_hit.
  - The cell HIT is sampled in that same cycle against the pre-move select.
- States:
  - IDLE:
    - poner_topo=0.
    - start -> clear score, misses, mole count -> SPAWN.
  - SPAWN:
    - If candidate >= N_CELLS, stay and retry next cycle.
    - Otherwise latch mole index, poner_topo=one-hot(index), load life timer = TOPO_TICKS-1, mole count+1 -> UP.
    - Mole index may equal the previous mole.
  - UP:
    - Timer decrements each cycle.
    - Any hit bit high -> score+1 (saturating), poner_topo=0, load cooldown timer -> COOL.
    - Else timer==0 -> misses+1, poner_topo=0 -> COOL.
    - Hit and timeout in the same cycle: hit wins; misses unchanged.
    - btn_hit with no hit -> no effect (whiff).
  - COOL:
    - Wait COOLDOWN_TICKS cycles.
    - Then mole count==GAME_MOLES -> DONE, else -> SPAWN.
  - DONE:
    - game_over=1; score and misses held.
    - start -> clear counters -> SPAWN.
- busy=1 in SPAWN, UP, COOL.
- start outside IDLE/DONE is ignored.
- Latency:
  - poner_topo rises 1 cycle after entering SPAWN with a valid candidate.
  - Mole visible exactly TOPO_TICKS cycles if unhit.
  - score updates the edge after the hit cycle.
- Invariant: score + misses == resolved moles <= GAME_MOLES.

Optional Feature:
- SPEEDUP_EN defined:
  - Per-game life value starts at TOPO_TICKS.
  - Each scored hit subtracts TOPO_TICKS/8 (integer), floored at TOPO_TICKS/4.
  - The reduced value is used at every subsequent SPAWN and is restored on start.
- SPEEDUP_EN undefined: life is always TOPO_TICKS; no extra registers.

Test Plan:
- Reset, then idle 10 cycles -> select=9'b000000001, poner_topo=0, score=0, misses=0, busy=0, game_over=0.
- Cursor at 0 (defaults): btn_left -> cursor 2; btn_up -> cursor 8; btn_right -> cursor 6; btn_down -> cursor 0; btn_up with btn_left same cycle -> cursor 6 only.
- start, no buttons, GAME_MOLES=4:
  - each mole stays up exactly 20 cycles;
  - first index equals the first lfsr[3:0]<9 after seed A5;
  - final misses=4, score=0, game_over=1.
- start, steer cursor to the mole index, btn_hit on the 5th UP cycle -> golpe high 1 cycle, poner_topo=0 next edge, score=1, COOL lasts 4 cycles.
- btn_hit on the cycle the timer reaches 0 with cursor on the mole -> score+1, misses unchanged.
- Mid-UP reset -> next edge all outputs at reset values; a following start begins with score=0.
- With SPEEDUP_EN: 4 consecutive hits -> mole lifetimes 20, 18, 16, 14; after start, lifetime is 20 again.
